mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares one memory port between the instruction-fetch requester (IFU, read-only) and the load/store requester (LSU, read/write).
- Sits between the datapath and a single memory instance. It replaces the separate instruction, read and write memory instances with one arbitrated port.
- Sequences each access through a grant / access / response FSM. The number of access cycles is a parameter, so slower memories can be modelled.

Parameters:
- MEM_LATENCY, 1, cycles mem_valid is held per access. Legal range ≥1.
- RESET_OWNER, 1, owner recorded in last_owner after reset: 0=IFU, 1=LSU. Used only when ARB_RR_EN is defined.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- ifu_req  input  1  IFU read request; held with ifu_addr until ifu_gnt
- ifu_addr  input  32  IFU fetch address
- ifu_gnt  output  1  one-cycle grant to IFU
- ifu_rvalid  output  1  one-cycle response valid to IFU
- ifu_rdata  output  32  IFU read data, valid with ifu_rvalid
- lsu_req  input  1  LSU request; held with its payload until lsu_gnt
- lsu_wen  input  1  1=write, 0=read
- lsu_addr  input  32  LSU address
- lsu_wdata  input  32  LSU write data
- lsu_wmask  input  8  LSU write byte mask
- lsu_gnt  output  1  one-cycle grant to LSU
- lsu_rvalid  output  1  one-cycle response to LSU; also the write acknowledge
- lsu_rdata  output  32  LSU read data; 0 for writes
- mem_valid  output  1  memory access enable
- mem_wen  output  1  memory write enable
- mem_raddr  output  32  memory read address
- mem_waddr  output  32  memory write address; same value as mem_raddr
- mem_wdata  output  32  memory write data
- mem_wmask  output  8  memory write mask
- mem_rdata  input  32  memory read data, combinational from mem_raddr
- busy  output  1  high whenever state≠IDLE

Behaviour:
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If any request is present, select a winner and assert that requester's gnt combinationally in the same cycle.
  - On the next clock edge: latch owner, addr, wen, wdata and wmask; load the counter with MEM_LATENCY−1; go to WAIT.
  - With no request, stay in IDLE.
- Arbitration with ARB_RR_EN undefined: fixed priority, LSU over IFU.
- WAIT:
  - mem_valid=1.
  - mem_raddr and mem_waddr driven from the latched addr.
  - mem_wdata and mem_wmask driven from the latched values.
  - mem_wen=latched wen, asserted only in the final WAIT cycle (counter==0), so each write is performed exactly once.
  - The counter decrements each cycle.
  - When counter==0: capture mem_rdata into the response register (for writes, capture 0 instead) and go to RESP.
- RESP:
  - The owner's rvalid=1 for exactly one cycle, with rdata from the response register.
  - The non-owner's rvalid and rdata stay 0.
  - Next state is always IDLE. There are no grants in RESP.
- Latency: with the gnt cycle as cycle 0, WAIT occupies cycles 1..MEM_LATENCY and rvalid is in cycle MEM_LATENCY+1. The earliest next grant is in cycle MEM_LATENCY+2.
- Requests that arrive while busy are not granted. They stay pending, and the requester must hold them.
- A request deasserted before its grant is silently dropped.
- Counter width: $clog2(MEM_LATENCY+1). With MEM_LATENCY=1 the FSM enters WAIT with counter=0.
- When no WAIT is active: mem_valid, mem_wen, mem_raddr, mem_waddr, mem_wdata and mem_wmask are all 0.
- Reset (rst low, asynchronous):
  - state=IDLE, counter=0, latched registers=0, response register=0, last_owner=RESET_OWNER.
  - Every output is 0, including both gnt, both rvalid, busy and all mem_* outputs.
  - Reset asserted mid-WAIT or mid-RESP discards the transaction. No rvalid is produced, and a write whose final WAIT cycle was not reached is not performed.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined:
  - Round-robin arbitration. A 1-bit last_owner register updates on every grant.
  - When both requesters are present in IDLE, the requester ≠ last_owner wins.
  - A single requester always wins.
- Undefined: fixed LSU priority, and no last_owner register is instantiated.

Test Plan:
- Reset: hold rst=0 with both reqs high → all outputs 0 and busy=0. After release, first grant on the next IDLE cycle.
- IFU read, MEM_LATENCY=2, ifu_addr=0x80000000, mem_rdata=0x00000013 → ifu_gnt at cycle 0; mem_valid in cycles 1–2 with mem_raddr=0x80000000; ifu_rvalid=1 and ifu_rdata=0x00000013 at cycle 3; mem_wen never set.
- LSU write, lsu_addr=0x80000010, lsu_wdata=0xDEADBEEF, lsu_wmask=0x0F, MEM_LATENCY=3 → mem_wen high only in cycle 3 with those values; lsu_rvalid=1 and lsu_rdata=0 at cycle 4.
- Simultaneous ifu_req and lsu_req held, fixed priority → lsu_gnt first; ifu_gnt at cycle MEM_LATENCY+2; each rvalid goes only to its own requester.
- ARB_RR_EN defined, RESET_OWNER=1, both reqs held for 4 transactions → grant order IFU, LSU, IFU, LSU.
- rst pulsed low during WAIT of an LSU write with MEM_LATENCY=4 at cycle 2 → mem_wen never asserts, no rvalid, state returns to IDLE, busy=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single memory port between the instruction-fetch
// unit (read-only) and the load/store unit (read/write).
// Each access runs grant -> MEM_LATENCY access cycles -> one response cycle.
// Build option: define ARB_RR_EN for round-robin arbitration with a
// last_owner register; otherwise the LSU has fixed priority over the IFU.
module mem_arbiter #(
  parameter int MEM_LATENCY = 1
`ifdef ARB_RR_EN
  ,
  parameter logic RESET_OWNER = 1'b1
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req,
  input  logic [31:0] ifu_addr,
  output logic        ifu_gnt,
  output logic        ifu_rvalid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_req,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [7:0]  lsu_wmask,
  output logic        lsu_gnt,
  output logic        lsu_rvalid,
  output logic [31:0] lsu_rdata,
  output logic        mem_valid,
  output logic        mem_wen,
  output logic [31:0] mem_raddr,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int             CW       = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(MEM_LATENCY - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
  // A single-cycle access makes the first WAIT cycle also the final one.
  localparam logic           LAT_ONE  = (MEM_LATENCY == 1) ? 1'b1 : 1'b0;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic          owner_r;        // 0 = IFU, 1 = LSU
  logic          wen_r;          // latched write flag of the active access
  logic          mem_valid_r;
  logic          mem_wen_r;
  logic [31:0]   mem_addr_r;
  logic [31:0]   mem_wdata_r;
  logic [7:0]    mem_wmask_r;
  logic          ifu_rvalid_r;
  logic          lsu_rvalid_r;
  logic [31:0]   ifu_rdata_r;
  logic [31:0]   lsu_rdata_r;
  logic          busy_r;

  logic          pick_lsu_s;
  logic          ifu_gnt_s;
  logic          lsu_gnt_s;

`ifdef ARB_RR_EN
  logic          last_owner_r;
`endif

  // Arbitration: choose a winner and raise its grant while idle and out of reset.
  always_comb begin
    pick_lsu_s = 1'b0;
    ifu_gnt_s  = 1'b0;
    lsu_gnt_s  = 1'b0;
`ifdef ARB_RR_EN
    if (lsu_req && ifu_req) begin
      pick_lsu_s = ~last_owner_r;
    end else begin
      pick_lsu_s = lsu_req;
    end
`else
    if (lsu_req) begin
      pick_lsu_s = 1'b1;
    end else begin
      pick_lsu_s = 1'b0;
    end
`endif
    if (rst && (state_r == ST_IDLE) && (ifu_req || lsu_req)) begin
      ifu_gnt_s = ~pick_lsu_s;
      lsu_gnt_s = pick_lsu_s;
    end else begin
      ifu_gnt_s = 1'b0;
      lsu_gnt_s = 1'b0;
    end
  end

  // Access sequencer: latch the winner, hold the memory port, then respond once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= CNT_ZERO;
      owner_r      <= 1'b0;
      wen_r        <= 1'b0;
      mem_valid_r  <= 1'b0;
      mem_wen_r    <= 1'b0;
      mem_addr_r   <= 32'h0000_0000;
      mem_wdata_r  <= 32'h0000_0000;
      mem_wmask_r  <= 8'h00;
      ifu_rvalid_r <= 1'b0;
      lsu_rvalid_r <= 1'b0;
      ifu_rdata_r  <= 32'h0000_0000;
      lsu_rdata_r  <= 32'h0000_0000;
      busy_r       <= 1'b0;
`ifdef ARB_RR_EN
      last_owner_r <= RESET_OWNER;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (ifu_gnt_s || lsu_gnt_s) begin
            state_r     <= ST_WAIT;
            cnt_r       <= CNT_LOAD;
            owner_r     <= lsu_gnt_s;
            mem_valid_r <= 1'b1;
            busy_r      <= 1'b1;
`ifdef ARB_RR_EN
            last_owner_r <= lsu_gnt_s;
`endif
            if (lsu_gnt_s) begin
              wen_r       <= lsu_wen;
              mem_addr_r  <= lsu_addr;
              mem_wdata_r <= lsu_wdata;
              mem_wmask_r <= lsu_wmask;
              mem_wen_r   <= lsu_wen & LAT_ONE;
            end else begin
              wen_r       <= 1'b0;
              mem_addr_r  <= ifu_addr;
              mem_wdata_r <= 32'h0000_0000;
              mem_wmask_r <= 8'h00;
              mem_wen_r   <= 1'b0;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (cnt_r == CNT_ZERO) begin
            // Final access cycle: capture the response and release the port.
            state_r      <= ST_RESP;
            mem_valid_r  <= 1'b0;
            mem_wen_r    <= 1'b0;
            mem_addr_r   <= 32'h0000_0000;
            mem_wdata_r  <= 32'h0000_0000;
            mem_wmask_r  <= 8'h00;
            ifu_rvalid_r <= ~owner_r;
            lsu_rvalid_r <= owner_r;
            ifu_rdata_r  <= (!owner_r && !wen_r) ? mem_rdata : 32'h0000_0000;
            lsu_rdata_r  <= (owner_r && !wen_r) ? mem_rdata : 32'h0000_0000;
          end else begin
            cnt_r     <= cnt_r - CNT_ONE;
            // Write strobe only in the cycle where the counter reaches zero.
            mem_wen_r <= wen_r & (cnt_r == CNT_ONE);
          end
        end
        ST_RESP: begin
          state_r      <= ST_IDLE;
          ifu_rvalid_r <= 1'b0;
          lsu_rvalid_r <= 1'b0;
          ifu_rdata_r  <= 32'h0000_0000;
          lsu_rdata_r  <= 32'h0000_0000;
          busy_r       <= 1'b0;
        end
        default: begin
          state_r      <= ST_IDLE;
          cnt_r        <= CNT_ZERO;
          mem_valid_r  <= 1'b0;
          mem_wen_r    <= 1'b0;
          mem_addr_r   <= 32'h0000_0000;
          mem_wdata_r  <= 32'h0000_0000;
          mem_wmask_r  <= 8'h00;
          ifu_rvalid_r <= 1'b0;
          lsu_rvalid_r <= 1'b0;
          ifu_rdata_r  <= 32'h0000_0000;
          lsu_rdata_r  <= 32'h0000_0000;
          busy_r       <= 1'b0;
        end
      endcase
    end
  end

  assign ifu_gnt    = ifu_gnt_s;
  assign lsu_gnt    = lsu_gnt_s;
  assign ifu_rvalid = ifu_rvalid_r;
  assign ifu_rdata  = ifu_rdata_r;
  assign lsu_rvalid = lsu_rvalid_r;
  assign lsu_rdata  = lsu_rdata_r;
  assign mem_valid  = mem_valid_r;
  assign mem_wen    = mem_wen_r;
  assign mem_raddr  = mem_addr_r;
  assign mem_waddr  = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign mem_wmask  = mem_wmask_r;
  assign busy       = busy_r;

endmodule
